// File: rtl/ice_bus_pkg.sv
// Shared slave-bus definitions: arbiter state encoding and idle-timeout width.
package ice_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_XFER    = 2'd2,
    ST_RELEASE = 2'd3
  } bus_state_t;

  localparam int TIMEOUT_W = 16;
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_DEFAULT = 16'd65535;

endpackage

// File: rtl/rr_pick.sv
// Round-robin search: first set request bit at or after ptr, wrapping modulo N.
// Purely combinational; ptr must be below N.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   ptr,
  output logic [2:0]   idx,
  output logic         found
);

  logic [7:0] req_ext;
  logic [3:0] cand;

  assign req_ext = 8'(req);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + 4'(k);
      if (cand >= 4'(N)) cand = cand - 4'(N);
      if (!found && req_ext[cand[2:0]]) begin
        found = 1'b1;
        idx   = cand[2:0];
      end
    end
  end

endmodule

// File: rtl/sl_arbiter.sv
// Round-robin slave-bus arbiter: grants one requester per frame and streams its
// bytes to the uplink, one bubble cycle per byte, with an idle-timeout release.
module sl_arbiter
  import ice_bus_pkg::*;
#(
  parameter int                     NUM_REQ = 4,
  parameter logic [TIMEOUT_W-1:0]   TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] sl_arb_request,
  output logic [NUM_REQ-1:0] sl_arb_grant,
  input  logic [7:0]         sl_data,
  output logic               sl_data_latch,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [2:0]         grant_idx,
  output logic               busy,
  output logic               timeout_err
);

  localparam logic [NUM_REQ-1:0] GRANT_ONE = NUM_REQ'(1);

  bus_state_t           state, state_nxt;
  logic [2:0]           rr_ptr, rr_ptr_nxt, grant_idx_nxt, pick_idx;
  logic                 pick_found;
  logic [TIMEOUT_W-1:0] idle_cnt, idle_cnt_nxt, idle_inc;
  logic [NUM_REQ-1:0]   grant_nxt;
  logic [7:0]           req_ext;
  logic                 req_granted;

  rr_pick #(.N(NUM_REQ)) u_rr_pick (
    .req   (sl_arb_request),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign req_ext     = 8'(sl_arb_request);
  assign req_granted = req_ext[grant_idx];
  assign idle_inc    = idle_cnt + TIMEOUT_W'(1);
  assign busy        = (state != ST_IDLE);
  // Bus data only passes through while a byte is actually offered.
  assign tx_data     = tx_valid ? sl_data : 8'h00;

  always_comb begin
    state_nxt     = state;
    grant_idx_nxt = grant_idx;
    rr_ptr_nxt    = rr_ptr;
    idle_cnt_nxt  = idle_cnt;
    grant_nxt     = sl_arb_grant;
    tx_valid      = 1'b0;
    sl_data_latch = 1'b0;
    timeout_err   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        grant_nxt = '0;
        if (pick_found) begin
          grant_idx_nxt = pick_idx;
          grant_nxt     = GRANT_ONE << pick_idx;
          idle_cnt_nxt  = '0;
          state_nxt     = ST_SETTLE;
        end
      end
      ST_SETTLE: state_nxt = ST_XFER;
      ST_XFER: begin
        if (!req_granted) begin
          grant_nxt = '0;
          state_nxt = ST_RELEASE;
        end else begin
          tx_valid = 1'b1;
          if (tx_ready) begin
            sl_data_latch = 1'b1;
            idle_cnt_nxt  = '0;
            state_nxt     = ST_SETTLE;
          end else if (idle_inc == TIMEOUT) begin
            // Stalled consumer: abandon the frame rather than block the bus.
            timeout_err = 1'b1;
            grant_nxt   = '0;
            state_nxt   = ST_RELEASE;
          end else begin
            idle_cnt_nxt = idle_inc;
          end
        end
      end
      ST_RELEASE: begin
        grant_nxt  = '0;
        rr_ptr_nxt = (grant_idx == 3'(NUM_REQ - 1)) ? 3'd0 : grant_idx + 3'd1;
        state_nxt  = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      grant_idx    <= '0;
      rr_ptr       <= '0;
      idle_cnt     <= '0;
      sl_arb_grant <= '0;
    end else begin
      state        <= state_nxt;
      grant_idx    <= grant_idx_nxt;
      rr_ptr       <= rr_ptr_nxt;
      idle_cnt     <= idle_cnt_nxt;
      sl_arb_grant <= grant_nxt;
    end
  end

endmodule

// File: tb/tb_sl_arbiter.sv
// Directed bench for sl_arbiter: cycle table for frame/empty-frame sequences,
// then fairness, backpressure, timeout and mid-frame reset sequences.
module tb_sl_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n;
  logic [N-1:0] req;
  logic [7:0]   dat;
  logic         rdy;

  logic [N-1:0] grant, grant8;
  logic         latch, latch8, valid, valid8, busy, busy8, terr, terr8;
  logic [7:0]   txd, txd8;
  logic [2:0]   gidx, gidx8;

  int checks = 0;
  int errors = 0;

  sl_arbiter #(.NUM_REQ(N), .TIMEOUT(16'd16)) dut (
    .clk(clk), .reset_n(reset_n), .sl_arb_request(req), .sl_arb_grant(grant),
    .sl_data(dat), .sl_data_latch(latch), .tx_data(txd), .tx_valid(valid),
    .tx_ready(rdy), .grant_idx(gidx), .busy(busy), .timeout_err(terr)
  );

  sl_arbiter #(.NUM_REQ(N), .TIMEOUT(16'd8)) dut8 (
    .clk(clk), .reset_n(reset_n), .sl_arb_request(req), .sl_arb_grant(grant8),
    .sl_data(dat), .sl_data_latch(latch8), .tx_data(txd8), .tx_valid(valid8),
    .tx_ready(rdy), .grant_idx(gidx8), .busy(busy8), .timeout_err(terr8)
  );

  typedef struct {
    logic [3:0] req;
    logic [7:0] dat;
    logic       rdy;
    logic [3:0] grant;
    logic       valid;
    logic [7:0] txd;
    logic       latch;
    logic       busy;
    logic [2:0] gidx;
  } vec_t;

  vec_t tbl[23];
  int   exp_ord[5] = '{0, 1, 2, 3, 0};

  logic [3:0] pending, g, prev_g;
  logic       l;
  int         n_gr, zrun;

  function automatic vec_t mk(logic [3:0] r, logic [7:0] d, logic rd, logic [3:0] eg,
                              logic ev, logic [7:0] ed, logic el, logic eb, logic [2:0] ei);
    vec_t v;
    v.req = r; v.dat = d; v.rdy = rd; v.grant = eg; v.valid = ev;
    v.txd = ed; v.latch = el; v.busy = eb; v.gidx = ei;
    return v;
  endfunction

  function automatic int oh2i(logic [3:0] oh);
    int r = -1;
    for (int i = 0; i < 4; i++) if (oh[i]) r = i;
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; req = '0; rdy = 1'b1; dat = '0;
    @(negedge clk);
    reset_n = 1'b1;
    next();
  endtask

  initial begin
    //            req     dat    rdy   grant   v  txd    l  b  gidx
    tbl[0]  = mk(4'b0100, 8'h00, 1, 4'b0000, 0, 8'h00, 0, 0, 3'd0);
    tbl[1]  = mk(4'b0100, 8'h64, 1, 4'b0100, 0, 8'h00, 0, 1, 3'd2);
    tbl[2]  = mk(4'b0100, 8'h64, 1, 4'b0100, 1, 8'h64, 1, 1, 3'd2);
    tbl[3]  = mk(4'b0100, 8'h11, 1, 4'b0100, 0, 8'h00, 0, 1, 3'd2);
    tbl[4]  = mk(4'b0100, 8'h11, 1, 4'b0100, 1, 8'h11, 1, 1, 3'd2);
    tbl[5]  = mk(4'b0100, 8'h22, 1, 4'b0100, 0, 8'h00, 0, 1, 3'd2);
    tbl[6]  = mk(4'b0100, 8'h22, 1, 4'b0100, 1, 8'h22, 1, 1, 3'd2);
    tbl[7]  = mk(4'b0000, 8'h00, 1, 4'b0100, 0, 8'h00, 0, 1, 3'd2);
    tbl[8]  = mk(4'b0000, 8'h00, 1, 4'b0100, 0, 8'h00, 0, 1, 3'd2);
    tbl[9]  = mk(4'b0000, 8'h00, 1, 4'b0000, 0, 8'h00, 0, 1, 3'd2);
    tbl[10] = mk(4'b1111, 8'h00, 1, 4'b0000, 0, 8'h00, 0, 0, 3'd2);
    tbl[11] = mk(4'b0000, 8'h00, 1, 4'b1000, 0, 8'h00, 0, 1, 3'd3);
    tbl[12] = mk(4'b0000, 8'h00, 1, 4'b1000, 0, 8'h00, 0, 1, 3'd3);
    tbl[13] = mk(4'b0000, 8'h00, 1, 4'b0000, 0, 8'h00, 0, 1, 3'd3);
    tbl[14] = mk(4'b0010, 8'h00, 1, 4'b0000, 0, 8'h00, 0, 0, 3'd3);
    tbl[15] = mk(4'b0001, 8'h00, 1, 4'b0010, 0, 8'h00, 0, 1, 3'd1);
    tbl[16] = mk(4'b0001, 8'h00, 1, 4'b0010, 0, 8'h00, 0, 1, 3'd1);
    tbl[17] = mk(4'b0001, 8'h00, 1, 4'b0000, 0, 8'h00, 0, 1, 3'd1);
    tbl[18] = mk(4'b0001, 8'h00, 1, 4'b0000, 0, 8'h00, 0, 0, 3'd1);
    tbl[19] = mk(4'b0000, 8'h00, 1, 4'b0001, 0, 8'h00, 0, 1, 3'd0);
    tbl[20] = mk(4'b0000, 8'h00, 1, 4'b0001, 0, 8'h00, 0, 1, 3'd0);
    tbl[21] = mk(4'b0000, 8'h00, 1, 4'b0000, 0, 8'h00, 0, 1, 3'd0);
    tbl[22] = mk(4'b0000, 8'h00, 1, 4'b0000, 0, 8'h00, 0, 0, 3'd0);

    reset_n = 1'b0; req = '0; dat = '0; rdy = 1'b1;
    #12;
    check("reset_state", {grant, valid, latch, busy, gidx, terr}, 32'd0);
    check("reset_state8", {grant8, valid8, latch8, busy8, gidx8, terr8}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    next();

    // Frame, request drop in SETTLE, empty frame, round-robin wrap
    for (int i = 0; i < 23; i++) begin
      req = tbl[i].req; dat = tbl[i].dat; rdy = tbl[i].rdy;
      @(negedge clk);
      check($sformatf("vec%0d", i),
            {grant, valid, txd, latch, busy, gidx, terr},
            {tbl[i].grant, tbl[i].valid, tbl[i].txd, tbl[i].latch, tbl[i].busy, tbl[i].gidx, 1'b0});
      next();
    end

    // Fairness: every requester always has one byte pending, refilled once ungranted
    do_reset();
    pending = 4'hF; n_gr = 0; zrun = 0; prev_g = '0;
    for (int cyc = 0; cyc < 80 && n_gr < 5; cyc++) begin
      req = pending; dat = 8'hC0; rdy = 1'b1;
      @(negedge clk);
      g = grant; l = latch;
      if (g != 0 && prev_g == 0) begin
        if (n_gr > 0) check("fair_gap", zrun, 2);
        check("fair_order", oh2i(g), exp_ord[n_gr]);
        n_gr++;
      end
      zrun = (g == 0) ? zrun + 1 : 0;
      prev_g = g;
      next();
      if (l) pending = pending & ~g;
      pending = pending | ~g;
    end
    check("fair_count", n_gr, 5);

    // Backpressure: 10 stalled XFER cycles stay below TIMEOUT=16
    do_reset();
    req = 4'b0001; dat = 8'h5A; rdy = 1'b0;
    repeat (2) next();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d", k), {valid, txd, latch, terr, grant},
            {1'b1, 8'h5A, 1'b0, 1'b0, 4'b0001});
      next();
    end
    rdy = 1'b1;
    @(negedge clk);
    check("bp_accept", {valid, txd, latch}, {1'b1, 8'h5A, 1'b1});
    next();

    // Timeout on the TIMEOUT=8 instance, then requester 1 is served
    do_reset();
    req = 4'b0011; dat = 8'h33; rdy = 1'b0;
    repeat (2) next();
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("to_stall%0d", k), {terr8, latch8, grant8},
            {(k == 8), 1'b0, 4'b0001});
      next();
    end
    @(negedge clk);
    check("to_drop", {grant8, busy8, terr8}, {4'b0000, 1'b1, 1'b0});
    repeat (2) next();
    @(negedge clk);
    check("to_next", {grant8, gidx8}, {4'b0010, 3'd1});
    next();

    // Reset mid-frame
    do_reset();
    req = 4'b0100; dat = 8'h77; rdy = 1'b0;
    repeat (2) next();
    #3;
    reset_n = 1'b0;
    #1;
    check("rst_async", {grant, valid, latch, busy}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1; req = 4'b1111;
    next();
    @(negedge clk);
    check("rst_first_grant", {grant, gidx, latch}, {4'b0001, 3'd0, 1'b0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sl_arbiter.md
SL_ARBITER -- requirements
Module: sl_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of slave-bus requesters (2..8).
REQ-002 Parameter TIMEOUT, default 16'd65535, maximum idle cycles in a granted frame before forced release.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 sl_arb_request  input  NUM_REQ  per-requester frame-pending flags.
REQ-006 sl_arb_grant  output  NUM_REQ  one-hot or zero grant vector; bit i enables requester i onto sl_data.
REQ-007 sl_data  input  8  shared slave data bus, driven by the granted requester.
REQ-008 sl_data_latch  output  1  one-cycle pulse that pops the current byte from the granted requester.
REQ-009 tx_data  output  8  byte to the uplink consumer.
REQ-010 tx_valid  output  1  tx_data is valid.
REQ-011 tx_ready  input  1  consumer accepts tx_data when tx_valid & tx_ready.
REQ-012 grant_idx  output  3  index of the current or last grantee.
REQ-013 busy  output  1  high whenever the state is not IDLE.
REQ-014 timeout_err  output  1  one-cycle pulse on a forced release.

Function
REQ-015 The FSM SHALL have states IDLE, SETTLE, XFER and RELEASE, with a registered state.
REQ-016 IDLE: if any request bit is set, the FSM SHALL select the first set bit at or after rr_ptr (wrapping modulo NUM_REQ), register it into grant_idx, and go to SETTLE; otherwise it stays in IDLE.
REQ-017 sl_arb_grant SHALL be a registered one-hot of grant_idx, asserted in SETTLE, XFER and RELEASE-entry, and all-zero in IDLE.
REQ-018 SETTLE SHALL last exactly 1 cycle (bus turnaround and FIFO pointer settle) and then go to XFER.
REQ-019 XFER: if sl_arb_request[grant_idx]==0, the FSM SHALL go to RELEASE with tx_valid low.
REQ-020 XFER: otherwise tx_valid=1 and tx_data=sl_data, both combinational.
REQ-021 XFER: on tx_valid & tx_ready, sl_data_latch SHALL pulse in the same cycle and the FSM SHALL go to SETTLE (one bubble per byte).
REQ-022 tx_valid SHALL never be high outside XFER.
REQ-023 sl_data_latch SHALL never pulse without tx_ready high in the same cycle.
REQ-024 tx_data SHALL hold stable while tx_valid is high and tx_ready is low.
REQ-025 A 16-bit idle counter SHALL clear on entry to SETTLE and on each latch, and increment each XFER cycle without a latch.
REQ-026 When the idle counter reaches TIMEOUT in XFER, timeout_err SHALL pulse, the grant SHALL drop and the FSM SHALL go to RELEASE; no latch pulses in that cycle.
REQ-027 RELEASE SHALL last 1 cycle with sl_arb_grant=0, set rr_ptr=grant_idx+1 (wrapping to 0 at NUM_REQ), then go to IDLE.
REQ-028 There SHALL be a minimum 2-cycle gap between grants to different requesters.
REQ-029 A requester re-asserting request during RELEASE SHALL NOT be favoured; round-robin order governs.
REQ-030 Request bits for non-granted requesters SHALL be ignored outside IDLE.
REQ-031 A request deasserted while in SETTLE SHALL be detected in the following XFER cycle, giving an empty frame that releases cleanly.
REQ-032 sl_data SHALL be sampled only in XFER.

Reset
REQ-033 Reset SHALL be asynchronous on reset_n low: state=IDLE, sl_arb_grant=0, grant_idx=0, rr_ptr=0, idle counter=0, tx_valid=0, sl_data_latch=0, busy=0, timeout_err=0.
REQ-034 Reset mid-frame SHALL drop the grant immediately; no latch pulse SHALL occur until after reset_n deassertion and a new IDLE arbitration.

Structure
REQ-035 The state encodings (2-bit) and the default TIMEOUT width SHALL live in a shared package ice_bus_pkg, used by all bus masters and slaves.
REQ-036 The round-robin first-set-bit search SHALL be a combinational sub-module rr_pick (inputs: request vector, pointer; outputs: index, found).
REQ-037 The rest SHALL be flat.

Verification
REQ-038 Single frame: req[2] high with 3 bytes 0x64,0x11,0x22, tx_ready=1 -> grant=0100 one cycle after detection; three latch pulses 2 cycles apart; tx_data sequence 0x64,0x11,0x22; req drop -> RELEASE -> IDLE; rr_ptr=3.
REQ-039 Fairness: req=1111 continuously, 1-byte frames -> grant order 0,1,2,3,0 with a 2-cycle gap between grants.
REQ-040 Backpressure: tx_ready low for 10 cycles mid-frame -> tx_valid held, tx_data stable, no latch, no timeout with TIMEOUT=16.
REQ-041 Timeout: TIMEOUT=8, tx_ready stuck low -> timeout_err pulses after 8 XFER cycles, grant drops, next requester is served.
REQ-042 Empty frame: req[1] pulses for 1 cycle -> grant, SETTLE, XFER sees req low, RELEASE; zero latch pulses.
REQ-043 Reset: reset_n asserted during XFER -> grant=0 and tx_valid=0 asynchronously; after release the first grant goes to requester 0 when req=1111.
